// File: rtl/instruction_stack_core.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_stack_core
//  Description : Return-address stack. A call pushes the caller's program
//                counter; a return pops the most recent entry and presents
//                entry + 1 (the return address) on a registered output.
//
//  Ports
//    clk      in   1           rising-edge clock
//    rst      in   1           asynchronous, active-low reset
//    i_PC     in   data_width  PC of the calling instruction (sampled on push)
//    call     in   1           push request (wins over rtrn)
//    rtrn     in   1           pop request
//    o_Stack  out  data_width  registered return address (popped entry + 1)
//    o_full   out  1           stack holds 2^addr_width entries
//    o_empty  out  1           stack holds no entries
//
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_stack_core #(
    parameter int addr_width = 4,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] i_PC,
    input  logic                  call,
    input  logic                  rtrn,
    output logic [data_width-1:0] o_Stack,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                  c_DEPTH   = 1 << addr_width;
    localparam logic [addr_width:0] c_SP_FULL = (addr_width + 1)'(c_DEPTH);
    localparam logic [addr_width:0] c_SP_ONE  = (addr_width + 1)'(1);
    localparam logic [data_width-1:0] c_INC   = data_width'(1);

    // Storage is deliberately not reset: entries above sp are unreachable.
    logic [data_width-1:0] r_mem [c_DEPTH];

    // Occupancy counter, one bit wider than the address so "full" is
    // distinguishable from "empty".
    logic [addr_width:0]   r_sp;

    logic                  w_push;
    logic                  w_pop;
    logic [addr_width:0]   w_sp_dec;
    logic [addr_width-1:0] w_wr_idx;
    logic [addr_width-1:0] w_rd_idx;

    assign o_full   = (r_sp == c_SP_FULL);
    assign o_empty  = (r_sp == '0);

    // call has priority: a simultaneous rtrn is dropped.
    assign w_push   = call && !o_full;
    assign w_pop    = rtrn && !call && !o_empty;

    assign w_sp_dec = r_sp - c_SP_ONE;
    assign w_wr_idx = r_sp[addr_width-1:0];
    assign w_rd_idx = w_sp_dec[addr_width-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp    <= '0;
            o_Stack <= '0;
        end else if (w_push) begin
            r_sp    <= r_sp + c_SP_ONE;
        end else if (w_pop) begin
            r_sp    <= w_sp_dec;
            // Wraps modulo 2^data_width by construction.
            o_Stack <= r_mem[w_rd_idx] + c_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= i_PC;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_stack_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_stack_core
//  Description : Self-checking bench for instruction_stack_core. A queue
//                model of the stack predicts o_Stack; predictions are pushed
//                to a scoreboard when stimulus is driven and popped after the
//                clock edge for comparison. Flags are checked each step.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_stack_core;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] i_PC = '0;
    logic          call = 1'b0;
    logic          rtrn = 1'b0;
    logic [DW-1:0] o_Stack;
    logic          o_full;
    logic          o_empty;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_stack = '0;

    instruction_stack_core #(
        .addr_width (AW),
        .data_width (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_PC    (i_PC),
        .call    (call),
        .rtrn    (rtrn),
        .o_Stack (o_Stack),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, check after posedge.
    task automatic step(input string tag, input logic c, input logic r, input logic [DW-1:0] pc);
        logic [DW-1:0] want;
        @(negedge clk);
        call = c;
        rtrn = r;
        i_PC = pc;
        if (c) begin
            if (model.size() < DEPTH) model.push_back(pc);
        end else if (r && model.size() > 0) begin
            exp_stack = model.pop_back() + 16'd1;
        end
        exp_q.push_back(exp_stack);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk({tag, ".o_Stack"}, 32'(o_Stack), 32'(want));
        chk({tag, ".o_empty"}, 32'(o_empty), 32'(model.size() == 0));
        chk({tag, ".o_full"},  32'(o_full),  32'(model.size() == DEPTH));
        call = 1'b0;
        rtrn = 1'b0;
    endtask

    // Reset pulse placed between clock edges; effect must be immediate.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model.delete();
        exp_q.delete();
        exp_stack = '0;
        chk({tag, ".rst_o_Stack"}, 32'(o_Stack), 32'h0);
        chk({tag, ".rst_o_empty"}, 32'(o_empty), 32'h1);
        chk({tag, ".rst_o_full"},  32'(o_full),  32'h0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset state
        #3;
        chk("por.o_Stack", 32'(o_Stack), 32'h0);
        chk("por.o_empty", 32'(o_empty), 32'h1);
        chk("por.o_full",  32'(o_full),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single call / return
        step("t1.push", 1'b1, 1'b0, 16'd10);
        step("t1.pop",  1'b0, 1'b1, 16'd0);
        chk("t1.result", 32'(o_Stack), 32'd11);

        // Nine pushes then nine pops, LIFO order
        pulse_reset("t2");
        for (int i = 1; i <= 9; i++) step("t2.push", 1'b1, 1'b0, DW'(i * 16));
        for (int i = 0; i < 9; i++) step("t2.pop", 1'b0, 1'b1, 16'd0);
        chk("t2.last", 32'(o_Stack), 32'h11);

        // Fill to full, ignored push, pop returns top + 1
        pulse_reset("t3");
        for (int i = 0; i < DEPTH; i++) step("t3.push", 1'b1, 1'b0, DW'(i));
        chk("t3.full", 32'(o_full), 32'h1);
        step("t3.push_full", 1'b1, 1'b0, 16'h0055);
        step("t3.pop", 1'b0, 1'b1, 16'd0);
        chk("t3.result", 32'(o_Stack), 32'd16);
        step("t3.pop2", 1'b0, 1'b1, 16'd0);
        chk("t3.result2", 32'(o_Stack), 32'd15);

        // Pop on empty ignored; 0xFFFF wraps to 0
        pulse_reset("t4");
        step("t4.pop_empty", 1'b0, 1'b1, 16'h1234);
        step("t4.push", 1'b1, 1'b0, 16'hFFFF);
        step("t4.idle", 1'b0, 1'b0, 16'h0000);
        step("t4.pop", 1'b0, 1'b1, 16'd0);
        chk("t4.wrap", 32'(o_Stack), 32'h0000);

        // Simultaneous call and rtrn: push only
        pulse_reset("t5");
        step("t5.push", 1'b1, 1'b0, 16'h0020);
        step("t5.both", 1'b1, 1'b1, 16'h0030);
        step("t5.pop1", 1'b0, 1'b1, 16'd0);
        chk("t5.first", 32'(o_Stack), 32'h31);
        step("t5.pop2", 1'b0, 1'b1, 16'd0);
        chk("t5.second", 32'(o_Stack), 32'h21);

        // Reset mid-sequence discards pending entries
        pulse_reset("t6");
        step("t6.push", 1'b1, 1'b0, 16'h0100);
        step("t6.push", 1'b1, 1'b0, 16'h0200);
        step("t6.pop",  1'b0, 1'b1, 16'd0);
        step("t6.push", 1'b1, 1'b0, 16'h0300);
        pulse_reset("t6b");
        step("t6.pop_after_rst", 1'b0, 1'b1, 16'd0);
        chk("t6.result", 32'(o_Stack), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_stack_core.md
INSTRUCTION_STACK_CORE -- requirements
Module: Instruction_Stack

Interface
REQ-001 Parameter addr_width, default 4: stack pointer width; depth = 2^addr_width entries (16 by default).
REQ-002 Parameter data_width, default 16: width of i_PC, stored entries and o_Stack.
REQ-003 clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-004 rst  input  1  asynchronous, active-low reset (rst = 0 resets immediately, regardless of clk).
REQ-005 i_PC  input  data_width  program counter value of the calling instruction, sampled on a push.
REQ-006 call  input  1  push request, sampled at the rising edge of clk.
REQ-007 rtrn  input  1  pop request, sampled at the rising edge of clk.
REQ-008 o_Stack  output  data_width  registered return address (popped entry + 1).
REQ-009 o_full  output  1  high when the stack holds 2^addr_width entries.
REQ-010 o_empty  output  1  high when the stack holds 0 entries.

Function
REQ-011 The block SHALL be a LIFO of 2^addr_width words of data_width bits with an occupancy counter sp of addr_width+1 bits (range 0..2^addr_width).
REQ-012 Push (call=1, rtrn=0, not full) SHALL write i_PC to entry sp and increment sp at the same clock edge; o_Stack is unchanged.
REQ-013 Pop (rtrn=1, call=0, not empty) SHALL load o_Stack with entry[sp-1] + 1 and decrement sp at the same clock edge; o_Stack is valid 1 cycle after the rtrn edge.
REQ-014 The +1 SHALL be computed modulo 2^data_width (0xFFFF returns 0x0000 at data_width 16).
REQ-015 Push while full SHALL be ignored: no write, sp, o_Stack and stored entries unchanged.
REQ-016 Pop while empty SHALL be ignored: sp and o_Stack unchanged.
REQ-017 call and rtrn both high at the same edge SHALL perform the push only (call has priority); rtrn is ignored.
REQ-018 Neither call nor rtrn high SHALL hold all state.
REQ-019 o_full = (sp == 2^addr_width) and o_empty = (sp == 0), both derived combinationally from sp.
REQ-020 Entries are not read except by pop; o_Stack SHALL NOT change on push.

Reset
REQ-021 rst low SHALL asynchronously set sp = 0, o_Stack = 0, o_empty = 1 and o_full = 0.
REQ-022 Memory entries are not required to be reset; they are unreachable while empty.
REQ-023 Reset asserted mid-sequence SHALL discard all pending entries; the next pop after reset is ignored.
REQ-024 Leaving reset (rst rising) SHALL take effect without waiting for a clock edge; the first edge with rst high may push or pop.

Verification
REQ-025 Reset; call with i_PC=10 for 1 edge; rtrn with i_PC=0 for 1 edge -> o_Stack=11, o_empty=1.
REQ-026 Reset; push 0x10,0x20,...,0x90 on 9 consecutive edges; then rtrn on 9 edges -> o_Stack = 0x91,0x81,...,0x11 after successive edges; o_empty=1 at end.
REQ-027 Reset; push 16 values 0..15 -> o_full=1; push 0x55 -> ignored; pop -> o_Stack=16 (15+1).
REQ-028 Reset; rtrn on empty stack -> o_Stack stays 0, sp stays 0; then push 0xFFFF, pop -> o_Stack=0x0000.
REQ-029 Push 0x20; call=1 and rtrn=1 with i_PC=0x30 on the same edge -> push only; two pops -> o_Stack=0x31 then 0x21.
REQ-030 Push 3 entries, pulse rst low between edges -> o_Stack=0 and o_empty=1 immediately; following pop leaves o_Stack=0.
